// File: rtl/lane_input_scheduler_if.sv
// lane_input_scheduler_if: press-event handshake between the scheduler and the judge unit
interface lane_input_scheduler_if #(
  parameter int IDXW = 2,
  parameter int TSW  = 16
);
  logic            valid;
  logic            ready;
  logic [IDXW-1:0] lane;
  logic [TSW-1:0]  ts;
  modport master (output valid, lane, ts, input ready);
  modport slave  (input valid, lane, ts, output ready);
endinterface

// File: rtl/lane_input_scheduler.sv
// lane_input_scheduler: timestamps lane presses and serialises them round-robin to the judge unit
module lane_input_scheduler #(
  parameter int NLANE = 4,
  parameter int IDXW  = 2,
  parameter int TSW   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   tick_i,
  input  logic                   ts_clr_i,
  input  logic [NLANE-1:0]       press_i,
  lane_input_scheduler_if.master out_o,
  output logic [NLANE-1:0]       pending_o,
  output logic [7:0]             drop_cnt_o
);
  typedef enum logic {IDLE, OFFER} state_e;
  state_e          state_q, state_d;
  logic [TSW-1:0]  ts_q, ts_d;
  logic [TSW-1:0]  cap_q [NLANE];
  logic [NLANE-1:0] pending_q, pending_d, pop_vec, accept, drop;
  logic [7:0]      drop_q, drop_d;
  logic            valid_q, valid_d, found;
  logic [IDXW-1:0] lane_q, lane_d, grant_q, grant_d, sel;
  logic [TSW-1:0]  out_ts_q, out_ts_d;
  // Game-tick timestamp; clear wins over tick, wraps naturally
  always_comb ts_d = ts_clr_i ? '0 : tick_i ? ts_q + 1'b1 : ts_q;
  // Per-lane capture: a press coinciding with its own lane's pop is re-armed, otherwise a busy lane drops it
  always_comb begin
    pop_vec = '0;
    pop_vec[lane_q] = valid_q & out_o.ready;
    accept = press_i & {NLANE{en_i}} & (~pending_q | pop_vec);
    drop = press_i & {NLANE{en_i}} & pending_q & ~pop_vec;
    pending_d = (pending_q & ~pop_vec) | accept;
    drop_d = (|drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  // Round-robin pick: first pending lane after the last granted one
  always_comb begin
    sel = grant_q;
    found = 1'b0;
    for (int k = 1; k <= NLANE; k++) begin
      if (!found && pending_q[(int'(grant_q) + k) % NLANE]) begin
        sel = IDXW'((int'(grant_q) + k) % NLANE);
        found = 1'b1;
      end
    end
  end
  // Offer FSM: load an event from IDLE, hold it in OFFER until the judge takes it
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    lane_d = lane_q;
    out_ts_d = out_ts_q;
    grant_d = grant_q;
    if (state_q == IDLE && found) begin
      state_d = OFFER;
      valid_d = 1'b1;
      lane_d = sel;
      out_ts_d = cap_q[sel];
    end else if (state_q == OFFER && out_o.ready) begin
      state_d = IDLE;
      valid_d = 1'b0;
      grant_d = lane_q;
    end
  end
  // Control and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ts_q <= '0;
      pending_q <= '0;
      drop_q <= '0;
      valid_q <= 1'b0;
      lane_q <= '0;
      out_ts_q <= '0;
      grant_q <= IDXW'(NLANE - 1);
    end else begin
      state_q <= state_d;
      ts_q <= ts_d;
      pending_q <= pending_d;
      drop_q <= drop_d;
      valid_q <= valid_d;
      lane_q <= lane_d;
      out_ts_q <= out_ts_d;
      grant_q <= grant_d;
    end
  end
  // Captured timestamps, the pre-increment ts of the accepting cycle
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NLANE; i++) begin
      if (!rst_ni) cap_q[i] <= '0;
      else if (accept[i]) cap_q[i] <= ts_q;
    end
  end
  assign out_o.valid = valid_q;
  assign out_o.lane = lane_q;
  assign out_o.ts = out_ts_q;
  assign pending_o = pending_q;
  assign drop_cnt_o = drop_q;
endmodule

// File: tb/tb_lane_input_scheduler.sv
// tb_lane_input_scheduler: randomized and directed scoreboard bench for lane_input_scheduler
module tb_lane_input_scheduler;
  localparam int NLANE = 4;
  localparam int IDXW = 2;
  localparam int TSW = 12;
  typedef struct {int lane; int ts;} ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, tick = 1'b0, clr = 1'b0;
  logic [NLANE-1:0] press = '0;
  logic [NLANE-1:0] pending;
  logic [7:0] drop_cnt;
  int tests = 0, fails = 0;
  ev_t q[$];
  int m_ts = 0, m_drop = 0, m_lane = 0, m_last = NLANE - 1;
  bit m_valid = 0;
  bit m_pend[NLANE];
  int m_cap[NLANE];
  bit o_pend[NLANE];
  int o_cap[NLANE];
  bit popped, dropped, hit;
  int w;
  lane_input_scheduler_if #(.IDXW(IDXW), .TSW(TSW)) bus ();
  lane_input_scheduler #(.NLANE(NLANE), .IDXW(IDXW), .TSW(TSW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .tick_i(tick), .ts_clr_i(clr),
    .press_i(press), .out_o(bus.master), .pending_o(pending), .drop_cnt_o(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, int a, int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(logic [NLANE-1:0] p, bit e, bit t, bit c, bit r);
    press = p; en = e; tick = t; clr = c; bus.ready = r;
    @(posedge clk);
    #2;
  endtask
  // Reference model: lane queues of one, rotating priority, event list pushed when offered
  always @(posedge clk) begin
    if (!rst_n) begin
      m_ts = 0; m_drop = 0; m_valid = 0; m_last = NLANE - 1; m_lane = 0;
      for (int i = 0; i < NLANE; i++) begin m_pend[i] = 0; m_cap[i] = 0; end
      q.delete();
    end else begin
      o_pend = m_pend;
      o_cap = m_cap;
      popped = m_valid && bus.ready;
      dropped = 0;
      for (int i = 0; i < NLANE; i++) begin
        if (press[i] && en) begin
          if (!o_pend[i] || (popped && m_lane == i)) begin m_pend[i] = 1; m_cap[i] = m_ts; end
          else dropped = 1;
        end else if (popped && m_lane == i) m_pend[i] = 0;
      end
      if (popped) begin
        m_valid = 0;
        m_last = m_lane;
      end else if (!m_valid) begin
        hit = 0;
        for (int k = 1; k <= NLANE; k++) begin
          if (!hit && o_pend[(m_last + k) % NLANE]) begin
            hit = 1;
            m_valid = 1;
            m_lane = (m_last + k) % NLANE;
            q.push_back('{m_lane, o_cap[m_lane]});
          end
        end
      end
      if (dropped && m_drop < 255) m_drop++;
      m_ts = clr ? 0 : tick ? (m_ts + 1) % (1 << TSW) : m_ts;
    end
  end
  // Monitor: compare status every cycle, consume expected events on handshake
  always @(negedge clk) begin
    int ep;
    ep = 0;
    for (int i = 0; i < NLANE; i++) ep += int'(m_pend[i]) << i;
    chk("valid", int'(bus.valid), int'(m_valid));
    chk("pending", int'(pending), ep);
    chk("drop_cnt", int'(drop_cnt), m_drop);
    if (rst_n && bus.valid) begin
      if (q.size() == 0) chk("event_expected", 1, 0);
      else begin
        chk("lane", int'(bus.lane), q[0].lane);
        chk("ts", int'(bus.ts), q[0].ts);
        if (bus.ready) void'(q.pop_front());
      end
    end
  end
  initial begin
    bus.ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) step('0, 1, 1, 0, 1);
    step(4'b0100, 1, 0, 0, 1);
    repeat (6) step('0, 1, 0, 0, 1);
    step(4'b1111, 1, 1, 0, 1);
    repeat (10) step('0, 1, 0, 0, 1);
    step(4'b1001, 1, 0, 0, 1);
    repeat (6) step('0, 1, 0, 0, 1);
    step(4'b0010, 1, 1, 0, 0);
    repeat (9) step('0, 1, 1, 0, 0);
    step(4'b0010, 1, 0, 0, 0);
    repeat (4) step('0, 1, 0, 0, 0);
    repeat (6) step('0, 1, 0, 0, 1);
    step(4'b0100, 1, 1, 0, 0);
    w = 0;
    while (!bus.valid && w < 20) begin step('0, 1, 1, 0, 0); w++; end
    chk("wait_offer", int'(bus.valid), 1);
    step(4'b0100, 1, 1, 0, 1);
    repeat (6) step('0, 1, 0, 0, 1);
    step('0, 1, 1, 1, 1);
    step(4'b0001, 1, 0, 0, 1);
    repeat (4) step('0, 1, 0, 0, 1);
    repeat ((1 << TSW) - 1) step('0, 1, 1, 0, 1);
    step(4'b1000, 1, 1, 0, 1);
    step(4'b0010, 1, 0, 0, 1);
    repeat (6) step('0, 1, 0, 0, 1);
    repeat (301) step(4'b0001, 1, 0, 0, 0);
    repeat (6) step('0, 1, 0, 0, 1);
    repeat (5) step(4'b1111, 0, 1, 0, 1);
    repeat (3) step('0, 0, 0, 0, 1);
    step(4'b0011, 1, 0, 0, 0);
    repeat (3) step('0, 1, 0, 0, 0);
    rst_n = 1'b0;
    step('0, 1, 0, 0, 1);
    rst_n = 1'b1;
    repeat (6) step('0, 1, 0, 0, 1);
    repeat (3000) begin
      rst_n = ($urandom % 500) != 0;
      step(NLANE'($urandom & $urandom), ($urandom % 8) != 0, $urandom % 2 == 0,
           ($urandom % 50) == 0, ($urandom % 3) != 0);
    end
    rst_n = 1'b1;
    repeat (20) step('0, 1, 0, 0, 1);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lane_input_scheduler.md
Name: lane_input_scheduler

Overview:
- Collects one-cycle press pulses from the per-lane button debouncers, one pulse per lane.
- Timestamps each press against a game-tick counter.
- Serialises the presses to the single judge/scoring unit over a valid/ready handshake.
- Round-robin arbitration makes simultaneous chords fair. Presses that arrive while the same lane is still unserved are counted as drops.

Parameters:
- NLANE, 4, number of button lanes (2..8)
- IDXW, 2, lane index width, equal to clog2(NLANE)
- TSW, 16, timestamp counter width

Ports:
- CLK  in  1  system clock, 100 MHz
- RST  in  1  synchronous, active-low reset; all state resets while RST==0 at posedge CLK
- EN  in  1  accept new presses (game running)
- TICK  in  1  one-cycle strobe that advances the timestamp counter
- TS_CLR  in  1  synchronous clear of the timestamp counter (song start)
- PRESS  in  NLANE  debounced rising-edge pulses, one bit per lane
- OUT_VALID  out  1  press event offered to the judge unit
- OUT_READY  in  1  judge unit accepts the event
- OUT_LANE  out  IDXW  lane index of the offered event
- OUT_TS  out  TSW  timestamp captured at press time
- PENDING  out  NLANE  per-lane unserved-press flags
- DROP_CNT  out  8  saturating count of dropped presses

Behaviour:
- Reset (RST==0):
  - ts, PENDING, DROP_CNT, OUT_LANE, OUT_TS = 0; OUT_VALID = 0.
  - FSM goes to IDLE.
  - last_grant = NLANE-1, so lane 0 has first priority.
  - Reset asserted mid-handshake discards all pending events; no event is emitted after reset release.
- Timestamp counter ts (TSW bits):
  - TS_CLR=1 → ts=0. TS_CLR has priority over TICK.
  - Otherwise TICK=1 → ts+1, wrapping from 2^TSW-1 to 0.
  - ts runs regardless of EN.
- Press capture, per lane i, evaluated each cycle:
  - accept = PRESS[i] & EN & (~PENDING[i] | pop_i). pop_i = OUT_VALID & OUT_READY & (OUT_LANE==i).
  - On accept: PENDING[i] is set (or stays set) next cycle, and ts_cap[i] takes the current ts, i.e. the pre-increment value in that cycle.
  - PRESS[i] & EN & PENDING[i] & ~pop_i → drop. The press is discarded and ts_cap[i] is unchanged.
  - DROP_CNT is +1 per cycle in which at least one drop occurs; it saturates at 255. Multiple lanes dropping in the same cycle count as 1.
  - pop_i without accept → PENDING[i] cleared.
  - EN=0 → all presses ignored (not counted as drops); already-pending lanes continue to drain.
- FSM:
  - IDLE:
    - If PENDING != 0: select the first set bit, scanning from last_grant+1 upward modulo NLANE.
    - Register OUT_LANE=sel, OUT_TS=ts_cap[sel], OUT_VALID=1; go to OFFER.
    - PENDING==0 → stay in IDLE with OUT_VALID=0.
  - OFFER:
    - OUT_VALID, OUT_LANE and OUT_TS hold stable until OUT_READY=1.
    - On handshake: OUT_VALID=0 next cycle, last_grant=OUT_LANE, go to IDLE.
- Timing:
  - Latency: press at cycle t → PENDING at t+1 → OUT_VALID at t+2 if the FSM is idle.
  - Throughput: at most 1 event per 2 cycles (one IDLE bubble between events).
- Lanes whose PENDING bit is set while OFFER is active wait for the next arbitration. Arbitration never preempts an offered event.
- OUT_READY while OUT_VALID=0 has no effect.

Test Plan:
1. Single press: reset, EN=1, TICK advances ts to 5, PRESS=4'b0100 for one cycle → OUT_VALID rises 2 cycles later with OUT_LANE=2, OUT_TS=5. With OUT_READY=1, PENDING returns to 0 and DROP_CNT=0.
2. Chord, round-robin order: PRESS=4'b1111 in one cycle, OUT_READY=1 → events emitted in lane order 0,1,2,3, every other cycle, all with the same OUT_TS. A following PRESS=4'b1001 yields lane 0, then lane 3.
3. Backpressure and drop: OUT_READY=0, press lane 1, then press lane 1 again 10 cycles later → OUT_LANE=1 and OUT_TS held stable throughout, DROP_CNT=1. OUT_READY=1 → one event only.
4. Press coincident with pop: lane 2 offered; a new PRESS[2] in the same cycle as the handshake, with ts=9 → no drop, PENDING[2] stays 1, next event is lane 2 with OUT_TS=9.
5. Counter edges:
   - TS_CLR and TICK asserted together → ts=0.
   - ts=16'hFFFF plus TICK → ts=0.
   - 300 drops → DROP_CNT=255.
6. Enable and reset: EN=0 with PRESS pulses → no events, DROP_CNT unchanged. Drive RST=0 while OUT_VALID=1 → next cycle OUT_VALID=0 and PENDING=0; after release no stale event appears.
